drive_status_tracker: RTL and testbench

Downstream stage of the manual-drive controller. It registers the controller's combinational `next_power`, `next_state` and `next_moving_state` into the current-state outputs that feed back into the controller. It accumulates a BCD odometer while the car is moving. It drives a 4-digit multiplexed 7-segment display of the mileage.

---
 rtl/drive_status_tracker_if.sv | 23 ++
 rtl/drive_status_tracker.sv | 184 ++++++++++++++++++
 tb/tb_drive_status_tracker.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/drive_status_tracker_if.sv
// Bundle between the manual-drive controller and its status tracker:
// next-state requests in, registered state, odometer and display out.
interface drive_status_tracker_if;
    logic        next_power;
    logic [1:0]  next_state;
    logic [3:0]  next_moving_state;
    logic        power;
    logic [1:0]  state;
    logic [3:0]  moving_state;
    logic [15:0] mileage;
    logic [3:0]  an;
    logic [7:0]  seg;

    modport master (
        output next_power, next_state, next_moving_state,
        input  power, state, moving_state, mileage, an, seg
    );

    modport slave (
        input  next_power, next_state, next_moving_state,
        output power, state, moving_state, mileage, an, seg
    );
endinterface

// File: rtl/drive_status_tracker.sv
// Registers the controller's next-state, accumulates a BCD odometer while
// moving and scans the mileage onto a 4-digit multiplexed 7-segment display.
module drive_status_tracker #(
    parameter int TICK_DIV    = 100000,
    parameter int MS_PER_UNIT = 1000,
    parameter int SCAN_MS     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    drive_status_tracker_if.slave  bus
);
    localparam int TW = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
    localparam int UW = (MS_PER_UNIT > 1) ? $clog2(MS_PER_UNIT) : 1;
    localparam int SW = (SCAN_MS > 1)     ? $clog2(SCAN_MS)     : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [UW-1:0] UNIT_LAST = UW'(MS_PER_UNIT - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_MS - 1);

    localparam logic [1:0] ST_NSTART = 2'b00;
    localparam logic [1:0] ST_START  = 2'b01;
    localparam logic [1:0] ST_MOVING = 2'b10;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    function automatic logic legal_motion(input logic [3:0] m);
        logic ok;
        case (m)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic          power_q,    power_d;
    logic [1:0]    state_q,    state_d;
    logic [3:0]    moving_q,   moving_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [UW-1:0] sub_q,      sub_d;
    logic [15:0]   mileage_q,  mileage_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    idx_q,      idx_d;
    logic [3:0]    an_q,       an_d;
    logic [7:0]    seg_q,      seg_d;

    logic          tick;
    logic          moving;
    logic [3:0]    digit;

    always_comb begin
        power_d = bus.next_power;
        case (bus.next_state)
            ST_NSTART, ST_START, ST_MOVING: state_d = bus.next_state;
            default:                        state_d = ST_NSTART;
        endcase
        moving_d = legal_motion(bus.next_moving_state) ? bus.next_moving_state : 4'b0000;
        if (!bus.next_power) begin
            state_d  = ST_NSTART;
            moving_d = 4'b0000;
        end
        if (state_d != ST_MOVING) begin
            moving_d = 4'b0000;
        end
    end

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end

    // Gating looks at the registered outputs, so a tick coinciding with a
    // falling next_power still counts.
    always_comb begin
        moving    = power_q && (state_q == ST_MOVING) && (moving_q != 4'b0000);
        sub_d     = sub_q;
        mileage_d = mileage_q;
        if (tick && moving) begin
            if (sub_q == UNIT_LAST) begin
                sub_d     = '0;
                mileage_d = bcd_inc(mileage_q);
            end else begin
                sub_d = sub_q + UW'(1);
            end
        end else if (!power_q) begin
            sub_d = '0;
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q;
        idx_d      = idx_q;
        if (tick) begin
            if (scan_cnt_q == SCAN_LAST) begin
                scan_cnt_d = '0;
                idx_d      = idx_q + 2'd1;
            end else begin
                scan_cnt_d = scan_cnt_q + SW'(1);
            end
        end
    end

    // an and seg come from the same index in the same register stage.
    always_comb begin
        case (idx_q)
            2'd0:    digit = mileage_q[3:0];
            2'd1:    digit = mileage_q[7:4];
            2'd2:    digit = mileage_q[11:8];
            default: digit = mileage_q[15:12];
        endcase
        an_d  = 4'b0000;
        seg_d = 8'h00;
        if (power_q) begin
            an_d  = 4'b0001 << idx_q;
            seg_d = seg_decode(digit);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            power_q    <= 1'b0;
            state_q    <= ST_NSTART;
            moving_q   <= 4'b0000;
            tick_cnt_q <= '0;
            sub_q      <= '0;
            mileage_q  <= 16'h0000;
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            an_q       <= 4'b0000;
            seg_q      <= 8'h00;
        end else begin
            power_q    <= power_d;
            state_q    <= state_d;
            moving_q   <= moving_d;
            tick_cnt_q <= tick_cnt_d;
            sub_q      <= sub_d;
            mileage_q  <= mileage_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.power        = power_q;
    assign bus.state        = state_q;
    assign bus.moving_state = moving_q;
    assign bus.mileage      = mileage_q;
    assign bus.an           = an_q;
    assign bus.seg          = seg_q;
endmodule

// File: tb/tb_drive_status_tracker.sv
// Bench for drive_status_tracker: cycle scoreboard against a behavioural
// model, directed checks, and a fast-tick instance for the 9999 wrap.
module tb_drive_status_tracker;
    localparam int TICK_DIV    = 4;
    localparam int MS_PER_UNIT = 3;
    localparam int SCAN_MS     = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    drive_status_tracker_if bus ();
    drive_status_tracker_if fb ();

    drive_status_tracker #(.TICK_DIV(TICK_DIV), .MS_PER_UNIT(MS_PER_UNIT), .SCAN_MS(SCAN_MS))
        u_dut (.clk(clk), .rst(rst), .bus(bus));

    drive_status_tracker #(.TICK_DIV(1), .MS_PER_UNIT(1), .SCAN_MS(1))
        u_fast (.clk(clk), .rst(rst), .bus(fb));

    typedef struct {
        logic        p;
        logic [1:0]  s;
        logic [3:0]  m;
        logic [15:0] mi;
        logic [3:0]  an;
        logic [7:0]  seg;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [7:0] SEG_TAB [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    int         P10 [4]      = '{1, 10, 100, 1000};

    // Behavioural model state (values as seen before the next edge)
    int m_tick, m_sub, m_miles, m_scan, m_idx, m_st, m_mv;
    bit m_pow;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_clear();
        m_tick = 0; m_sub = 0; m_miles = 0; m_scan = 0; m_idx = 0;
        m_st = 0; m_mv = 0; m_pow = 1'b0;
    endtask

    task automatic step();
        exp_t e;
        exp_t g;
        bit   tk, mv;
        int   st, mvn;
        tk = (m_tick == TICK_DIV - 1);
        mv = m_pow && (m_st == 2) && (m_mv != 0);
        if (m_pow) begin
            e.an  = 4'(1 << m_idx);
            e.seg = SEG_TAB[(m_miles / P10[m_idx]) % 10];
        end else begin
            e.an  = 4'h0;
            e.seg = 8'h00;
        end
        if (tk && mv) begin
            if (m_sub == MS_PER_UNIT - 1) begin
                m_sub   = 0;
                m_miles = (m_miles + 1) % 10000;
            end else begin
                m_sub++;
            end
        end else if (!m_pow) begin
            m_sub = 0;
        end
        if (tk) begin
            if (m_scan == SCAN_MS - 1) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % 4;
            end else begin
                m_scan++;
            end
        end
        m_tick = tk ? 0 : m_tick + 1;
        m_pow  = bus.next_power;
        st     = int'(bus.next_state);
        if (st == 3 || !m_pow) st = 0;
        mvn = int'(bus.next_moving_state);
        if (!(mvn inside {0, 1, 2, 4, 8}) || st != 2) mvn = 0;
        m_st = st;
        m_mv = mvn;
        e.p  = m_pow;
        e.s  = 2'(m_st);
        e.m  = 4'(m_mv);
        e.mi = to_bcd(m_miles);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        g = sb_q.pop_front();
        chk("sb_power",   16'(bus.power),        16'(g.p));
        chk("sb_state",   16'(bus.state),        16'(g.s));
        chk("sb_moving",  16'(bus.moving_state), 16'(g.m));
        chk("sb_mileage", bus.mileage,           g.mi);
        chk("sb_an",      16'(bus.an),           16'(g.an));
        chk("sb_seg",     16'(bus.seg),          16'(g.seg));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive(input logic p, input logic [1:0] s, input logic [3:0] m);
        bus.next_power        = p;
        bus.next_state        = s;
        bus.next_moving_state = m;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_power"},   16'(bus.power),        16'h0);
        chk({tag, "_state"},   16'(bus.state),        16'h0);
        chk({tag, "_moving"},  16'(bus.moving_state), 16'h0);
        chk({tag, "_mileage"}, bus.mileage,           16'h0);
        chk({tag, "_an"},      16'(bus.an),           16'h0);
        chk({tag, "_seg"},     16'(bus.seg),          16'h0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check_zero({tag, "_async"});
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 2'($urandom), 4'($urandom));
            @(posedge clk);
            #1;
        end
        check_zero({tag, "_hold"});
        model_clear();
        sb_q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic move_until(input logic [15:0] target, input int budget);
        int n;
        n = 0;
        while (bus.mileage !== target && n < budget) begin
            step();
            n++;
        end
        chk("reach_target", bus.mileage, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] chg_q[$];
        logic [15:0] prev_m;
        logic [3:0]  prev_an;
        logic [3:0]  seen;
        logic [7:0]  exp_seg;
        int          last_chg;
        int          gap_miles;

        fb.next_power = 1'b0; fb.next_state = 2'b00; fb.next_moving_state = 4'b0000;
        drive(1'b0, 2'b00, 4'b0000);
        #1;

        // 1: reset with random inputs, then power up to START
        do_reset("reset");
        drive(1'b1, 2'b01, 4'b0000);
        step();
        chk("t1_power", 16'(bus.power), 16'h1);
        chk("t1_state", 16'(bus.state), 16'h1);

        // 2: 36 cycles of forward motion -> three units, 12 cycles apart
        drive(1'b1, 2'b10, 4'b0001);
        prev_m = bus.mileage;
        for (int i = 0; i < 36; i++) begin
            step();
            if (bus.mileage !== prev_m) chg_q.push_back(16'(cyc));
            prev_m = bus.mileage;
        end
        chk("t2_mileage", bus.mileage, 16'h0003);
        chk("t2_changes", 16'(chg_q.size()), 16'd3);
        for (int i = 1; i < chg_q.size(); i++) chk("t2_spacing", chg_q[i] - chg_q[i-1], 16'd12);

        // 3a: partial unit survives a START pause
        steps(8);
        drive(1'b1, 2'b01, 4'b0001);
        steps(20);
        chk("t3_pause_hold", bus.mileage, 16'h0003);
        drive(1'b1, 2'b10, 4'b0001);
        steps(6);
        chk("t3_pause_resume", bus.mileage, 16'h0004);

        // 3b: power loss discards the partial unit
        steps(8);
        drive(1'b0, 2'b10, 4'b0001);
        steps(20);
        gap_miles = m_miles;
        drive(1'b1, 2'b10, 4'b0001);
        steps(8);
        chk("t3_pwr_hold", bus.mileage, to_bcd(gap_miles));
        steps(8);
        chk("t3_pwr_resume", bus.mileage, to_bcd(gap_miles + 1));

        // 4: digit carry 0099 -> 0100
        drive(1'b1, 2'b10, 4'b1000);
        move_until(16'h0099, 2000);
        steps(1);
        move_until(16'h0100, 20);

        // 5: illegal encodings
        drive(1'b1, 2'b11, 4'b0001);
        step();
        chk("t5_state11", 16'(bus.state), 16'h0);
        drive(1'b1, 2'b10, 4'b0011);
        step();
        chk("t5_mv0011", 16'(bus.moving_state), 16'h0);
        chk("t5_mv0011_state", 16'(bus.state), 16'h2);
        gap_miles = m_miles;
        steps(24);
        chk("t5_no_accum", bus.mileage, to_bcd(gap_miles));
        drive(1'b1, 2'b01, 4'b0001);
        step();
        chk("t5_start_fwd", 16'(bus.moving_state), 16'h0);

        // 6: display of 0123
        drive(1'b1, 2'b10, 4'b0010);
        move_until(16'h0123, 400);
        drive(1'b1, 2'b01, 4'b0000);
        steps(2);
        seen = 4'h0;
        prev_an = bus.an;
        last_chg = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            case (bus.an)
                4'b0001: exp_seg = 8'h4F;
                4'b0010: exp_seg = 8'h5B;
                4'b0100: exp_seg = 8'h06;
                4'b1000: exp_seg = 8'h3F;
                default: exp_seg = 8'hFF;
            endcase
            chk("t6_seg", 16'(bus.seg), 16'(exp_seg));
            seen = seen | bus.an;
            if (bus.an !== prev_an) begin
                chk("t6_an_order", 16'(bus.an), 16'({prev_an[2:0], prev_an[3]}));
                if (last_chg >= 0) chk("t6_an_dwell", 16'(cyc - last_chg), 16'd4);
                last_chg = cyc;
            end
            prev_an = bus.an;
        end
        chk("t6_an_cover", 16'(seen), 16'h000F);
        drive(1'b0, 2'b01, 4'b0000);
        step();
        chk("t6_off_power", 16'(bus.power), 16'h0);
        step();
        chk("t6_off_an", 16'(bus.an), 16'h0);
        chk("t6_off_seg", 16'(bus.seg), 16'h0);
        chk("t6_off_keep", bus.mileage, 16'h0123);

        // reset in the middle of a count, then count from zero again
        drive(1'b1, 2'b10, 4'b0100);
        steps(10);
        #2;
        do_reset("midrst");
        steps(36);
        chk("rst_recount", bus.mileage, 16'h0003);

        // 9999 -> 0000 on the every-cycle instance
        fb.next_power = 1'b1; fb.next_state = 2'b10; fb.next_moving_state = 4'b0001;
        @(posedge clk);
        #1;
        chk("fast_start", fb.mileage, 16'h0000);
        for (int k = 1; k <= 10000; k++) begin
            @(posedge clk);
            #1;
            if (k % 50 == 0 || k >= 9990) chk("fast_mileage", fb.mileage, to_bcd(k % 10000));
        end
        chk("fast_wrap", fb.mileage, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
